// File: rtl/contador_param_if.sv
// Control and status bundle for contador_param: count controls in, count state out.
interface contador_param_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic [1:0]       M;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] G;
  logic             TC;
  logic             DIR;

  modport master (output EN, LD, D, M, input Q, G, TC, DIR);
  modport slave  (input EN, LD, D, M, output Q, G, TC, DIR);
endinterface

// File: rtl/contador_param.sv
// Bounded, loadable modulo counter with up/down/bounce/hold modes, falling-edge
// clocked, with a combinational terminal-count flag and Gray-coded count copy.
module contador_param #(
  parameter int WIDTH   = 4,
  parameter int MIN     = 0,
  parameter int MAX     = 15,
  parameter int RST_VAL = 0
) (
  input  logic C,
  input  logic R,
  contador_param_if.slave bus
);

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  dir_e             dir_q, dir_d;
  mode_e            mode;
  logic             below_min;
  logic             above_max;
  logic             at_end;
  logic [WIDTH-1:0] load_val;

  assign mode = mode_e'(bus.M);

  // Range checks on the load value exist only when the bound is not the
  // natural limit of the WIDTH-bit range, so no always-false compare is built.
  if (MIN > 0) begin : g_lo_chk
    assign below_min = (bus.D < MIN_V);
  end else begin : g_lo_none
    assign below_min = 1'b0;
  end

  if (MAX < (2 ** WIDTH) - 1) begin : g_hi_chk
    assign above_max = (bus.D > MAX_V);
  end else begin : g_hi_none
    assign above_max = 1'b0;
  end

  assign load_val = above_max ? MAX_V : (below_min ? MIN_V : bus.D);

  // Next count and direction: load, then enable gate, then mode step.
  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    if (bus.LD) begin
      q_d = load_val;
    end else if (bus.EN) begin
      case (mode)
        M_UP: begin
          q_d   = (q_q == MAX_V) ? MIN_V : q_q + ONE;
          dir_d = DIR_UP;
        end
        M_DOWN: begin
          q_d   = (q_q == MIN_V) ? MAX_V : q_q - ONE;
          dir_d = DIR_DN;
        end
        M_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (q_q == MAX_V) begin
              q_d   = MAX_V - ONE;
              dir_d = DIR_DN;
            end else begin
              q_d = q_q + ONE;
            end
          end else begin
            if (q_q == MIN_V) begin
              q_d   = MIN_V + ONE;
              dir_d = DIR_UP;
            end else begin
              q_d = q_q - ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Count state register, stepped on the falling edge, async reset to RST_VAL.
  always_ff @(negedge C or posedge R) begin
    if (R) begin
      q_q   <= RST_V;
      dir_q <= DIR_UP;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
    end
  end

  // Endpoint detect: the next enabled step of the current mode wraps or reverses.
  always_comb begin
    at_end = 1'b0;
    case (mode)
      M_UP:     at_end = (q_q == MAX_V);
      M_DOWN:   at_end = (q_q == MIN_V);
      M_BOUNCE: at_end = (dir_q == DIR_UP) ? (q_q == MAX_V) : (q_q == MIN_V);
      default:  at_end = 1'b0;
    endcase
  end

  assign bus.Q   = q_q;
  assign bus.G   = q_q ^ (q_q >> 1);
  assign bus.DIR = dir_q;
  assign bus.TC  = ~R & bus.EN & ~bus.LD & at_end;

endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench for contador_param with WIDTH=4, MIN=3, MAX=12, RST_VAL=10.
module tb_contador_param;

  typedef struct packed {
    logic [3:0] q;
    logic       dir;
    logic       tc;
    logic [3:0] g;
  } exp_t;

  logic C = 1'b1;
  logic R = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  contador_param_if #(.WIDTH(4)) bus ();

  contador_param #(
    .WIDTH(4),
    .MIN(3),
    .MAX(12),
    .RST_VAL(10)
  ) dut (
    .C(C),
    .R(R),
    .bus(bus)
  );

  always #5 C = ~C;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [3:0] gray(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 3; i++) r[i] = v[i] ^ v[i+1];
    r[3] = v[3];
    return r;
  endfunction

  task automatic set_in(input logic en, input logic ld, input logic [3:0] d, input logic [1:0] m);
    bus.EN = en;
    bus.LD = ld;
    bus.D  = d;
    bus.M  = m;
  endtask

  task automatic test_reset;
    set_in(1'b1, 1'b0, 4'd0, 2'b00);
    R = 1'b1;
    #12;
    checks++;
    if ({bus.Q, bus.DIR, bus.TC, bus.G} !== {4'd10, 1'b0, 1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL reset: Q=%0d DIR=%b TC=%b G=%b, expected Q=10 DIR=0 TC=0 G=1111",
               bus.Q, bus.DIR, bus.TC, bus.G);
    end
    R = 1'b0;
  endtask

  task automatic test_up;
    logic [3:0] eq [5];
    exp_t e;
    eq = '{4'd11, 4'd12, 4'd3, 4'd4, 4'd5};
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b0, 4'd0, 2'b00);
      sb.push_back('{q: eq[k], dir: 1'b0, tc: (eq[k] == 4'd12), g: gray(eq[k])});
      @(negedge C); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
        errors++;
        $display("FAIL up step %0d: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
                 k, bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
      end
    end
  endtask

  task automatic test_down;
    logic       ld [4];
    logic [3:0] eq [4];
    logic       ed [4];
    logic       et [4];
    exp_t e;
    ld = '{1'b1, 1'b0, 1'b0, 1'b0};
    eq = '{4'd4, 4'd3, 4'd12, 4'd11};
    ed = '{1'b0, 1'b1, 1'b1, 1'b1};
    et = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, ld[k], 4'd4, 2'b01);
      sb.push_back('{q: eq[k], dir: ed[k], tc: et[k], g: gray(eq[k])});
      @(negedge C); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
        errors++;
        $display("FAIL down step %0d: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
                 k, bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
      end
    end
  endtask

  task automatic test_bounce;
    exp_t e;
    int   c;
    logic [3:0] q;
    logic d;
    // Position to Q=11, DIR=0: load 10 (DIR stays 1), then one up step.
    for (int k = 0; k < 20; k++) begin
      if (k == 0) begin
        set_in(1'b1, 1'b1, 4'd10, 2'b01);
        sb.push_back('{q: 4'd10, dir: 1'b1, tc: 1'b0, g: gray(4'd10)});
      end else if (k == 1) begin
        set_in(1'b1, 1'b0, 4'd0, 2'b00);
        sb.push_back('{q: 4'd11, dir: 1'b0, tc: 1'b0, g: gray(4'd11)});
      end else begin
        // Cycle position c: 0 is Q=3 arriving downward, 1..9 rising, 10..17 falling.
        c = (8 + (k - 1)) % 18;
        if (c == 0) begin
          q = 4'd3; d = 1'b1;
        end else if (c <= 9) begin
          q = 4'(3 + c); d = 1'b0;
        end else begin
          q = 4'(21 - c); d = 1'b1;
        end
        set_in(1'b1, 1'b0, 4'd0, 2'b10);
        sb.push_back('{q: q, dir: d, tc: (c == 0 || c == 9), g: gray(q)});
      end
      @(negedge C); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
        errors++;
        $display("FAIL bounce step %0d: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
                 k, bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
      end
    end
  endtask

  task automatic test_load;
    logic [3:0] dv [3];
    logic [3:0] eq [3];
    exp_t e;
    dv = '{4'd7, 4'd1, 4'd15};
    eq = '{4'd7, 4'd3, 4'd12};
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b1, dv[k], 2'b10);
      sb.push_back('{q: eq[k], dir: 1'b0, tc: 1'b0, g: gray(eq[k])});
      @(negedge C); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
        errors++;
        $display("FAIL load D=%0d: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
                 dv[k], bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
      end
    end
  endtask

  task automatic test_hold;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (k < 2) set_in(1'b0, 1'b0, 4'd0, 2'b00);
      else       set_in(1'b1, 1'b0, 4'd0, 2'b11);
      sb.push_back('{q: 4'd12, dir: 1'b0, tc: 1'b0, g: gray(4'd12)});
      @(negedge C); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
        errors++;
        $display("FAIL hold step %0d: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
                 k, bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] eq [6];
    exp_t e;
    eq = '{4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6};
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, 1'b0, 4'd0, 2'b10);
      sb.push_back('{q: eq[k], dir: 1'b1, tc: 1'b0, g: gray(eq[k])});
      @(negedge C); #1;
      e = sb.pop_front();
      checks++;
      if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
        errors++;
        $display("FAIL pre-reset bounce step %0d: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
                 k, bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
      end
    end
    #1;
    R = 1'b1;
    #1;
    checks++;
    if ({bus.Q, bus.DIR, bus.TC} !== {4'd10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async reset: Q=%0d DIR=%b TC=%b, expected Q=10 DIR=0 TC=0",
               bus.Q, bus.DIR, bus.TC);
    end
    @(negedge C); #1;
    checks++;
    if ({bus.Q, bus.DIR} !== {4'd10, 1'b0}) begin
      errors++;
      $display("FAIL reset holds across edge: Q=%0d DIR=%b, expected Q=10 DIR=0", bus.Q, bus.DIR);
    end
    R = 1'b0;
    sb.push_back('{q: 4'd11, dir: 1'b0, tc: 1'b0, g: gray(4'd11)});
    @(negedge C); #1;
    e = sb.pop_front();
    checks++;
    if ({bus.Q, bus.DIR, bus.TC, bus.G} !== e) begin
      errors++;
      $display("FAIL first edge after reset: Q=%0d DIR=%b TC=%b G=%b, expected Q=%0d DIR=%b TC=%b G=%b",
               bus.Q, bus.DIR, bus.TC, bus.G, e.q, e.dir, e.tc, e.g);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_bounce();
    test_load();
    test_hold();
    test_reset_mid();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
